// File: rtl/acc_pkg.sv
// acc_pkg: shared state encoding and default sizing for the product accumulator.
package acc_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    localparam int DEF_VEC_LEN = 8;
    localparam int DEF_PROD_W  = 16;
    localparam int DEF_ACC_W   = 20;
endpackage

// File: rtl/sat_adder.sv
// sat_adder: W-bit signed adder that clamps to the representable range and flags the clamp.
module sat_adder #(
    parameter int W = 20
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] sum_o,
    output logic                ovf_o
);
    localparam logic signed [W-1:0] MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
    logic [W:0] raw;
    assign raw   = {a_i[W-1], a_i} + {b_i[W-1], b_i};
    // The two top bits disagree exactly when the true sum left the W-bit range.
    assign ovf_o = raw[W] ^ raw[W-1];
    assign sum_o = !ovf_o ? raw[W-1:0] : raw[W] ? MIN : MAX;
endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: sums VEC_LEN signed products with saturation and hands the result
// downstream over a valid/ready pair.
module product_accumulator
    import acc_pkg::*;
#(
    parameter int VEC_LEN = DEF_VEC_LEN,
    parameter int PROD_W  = DEF_PROD_W,
    parameter int ACC_W   = DEF_ACC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PROD_W-1:0] in_product,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_sum,
    output logic                     out_sat
);
    localparam int CW = $clog2(VEC_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(VEC_LEN);
    state_t                 state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, prod_ext, add_sum;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
    logic                   sat_q, sat_d, add_ovf, xfer;
    assign prod_ext  = {{(ACC_W-PROD_W){in_product[PROD_W-1]}}, in_product};
    assign in_ready  = state_q != HOLD;
    assign out_valid = state_q == HOLD;
    assign out_sum   = acc_q;
    assign out_sat   = sat_q;
    assign xfer      = in_valid && in_ready;
    assign cnt_inc   = cnt_q + CW'(1);
    sat_adder #(.W(ACC_W)) u_add (
        .a_i  (acc_q),
        .b_i  (prod_ext),
        .sum_o(add_sum),
        .ovf_o(add_ovf)
    );
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        unique case (state_q)
            IDLE: if (xfer) begin
                acc_d   = prod_ext;
                cnt_d   = CW'(1);
                sat_d   = 1'b0;
                state_d = CW'(1) == LAST ? HOLD : ACCUM;
            end
            ACCUM: if (xfer) begin
                acc_d   = add_sum;
                cnt_d   = cnt_inc;
                sat_d   = sat_q | add_ovf;
                state_d = cnt_inc == LAST ? HOLD : ACCUM;
            end
            HOLD: if (out_ready) begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: drives two accumulators (20- and 17-bit) with identical traffic and
// checks every presented result against a clamped-sum reference held in per-width scoreboards.
module tb_product_accumulator;
    localparam int VL = 8;
    localparam int PW = 16;
    typedef struct {
        longint sum;
        logic   sat;
    } exp_t;
    logic clk = 1'b0;
    logic rst, in_valid, out_ready;
    logic signed [PW-1:0] in_product;
    logic rdy20, rdy17, v20, v17, sat20, sat17;
    logic signed [19:0] sum20;
    logic signed [16:0] sum17;
    int n_chk = 0;
    int n_fail = 0;
    int mode = 0;
    exp_t sb[2][$];
    longint cur[$];
    always #5 clk = ~clk;
    product_accumulator #(.VEC_LEN(VL), .PROD_W(PW), .ACC_W(20)) u20 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy20), .in_product(in_product),
        .out_valid(v20), .out_ready(out_ready), .out_sum(sum20), .out_sat(sat20)
    );
    product_accumulator #(.VEC_LEN(VL), .PROD_W(PW), .ACC_W(17)) u17 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy17), .in_product(in_product),
        .out_valid(v17), .out_ready(out_ready), .out_sum(sum17), .out_sat(sat17)
    );
    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask
    function automatic exp_t model(input longint p[$], input int w);
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        longint lo = -(longint'(1) <<< (w - 1));
        exp_t r;
        r.sum = 0;
        r.sat = 1'b0;
        foreach (p[i]) begin
            r.sum += p[i];
            if (r.sum > hi) begin
                r.sum = hi;
                r.sat = 1'b1;
            end else if (r.sum < lo) begin
                r.sum = lo;
                r.sat = 1'b1;
            end
        end
        return r;
    endfunction
    always @(posedge clk) begin
        #1;
        out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(1)) : 1'b0;
    end
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                logic v, r, s;
                longint sm;
                exp_t e;
                v  = d == 0 ? v20 : v17;
                r  = d == 0 ? rdy20 : rdy17;
                s  = d == 0 ? sat20 : sat17;
                sm = d == 0 ? longint'(sum20) : longint'(sum17);
                chk(d == 0 ? "in_ready_vs_hold[20]" : "in_ready_vs_hold[17]", r, !v);
                if (v) begin
                    if (sb[d].size() == 0) chk("out_valid_without_result", v, 0);
                    else begin
                        e = sb[d][0];
                        chk(d == 0 ? "out_sum[20]" : "out_sum[17]", sm, e.sum);
                        chk(d == 0 ? "out_sat[20]" : "out_sat[17]", s, e.sat);
                        if (out_ready) void'(sb[d].pop_front());
                    end
                end
            end
        end
    end
    task automatic send(input logic signed [PW-1:0] p, input int bub);
        logic r;
        int g = 0;
        while ($urandom_range(99) < bub) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid   = 1'b1;
        in_product = p;
        do begin
            @(negedge clk);
            r = rdy20;
            @(posedge clk); #1;
            g++;
        end while (!r && g < 200);
        in_valid = 1'b0;
        if (!r) chk("send_timeout", r, 1);
        else begin
            cur.push_back(longint'(p));
            if (cur.size() == VL) begin
                sb[0].push_back(model(cur, 20));
                sb[1].push_back(model(cur, 17));
                cur.delete();
            end
        end
    endtask
    task automatic send_list(input longint p[$], input int bub);
        foreach (p[i]) send(16'(p[i]), bub);
    endtask
    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        sb[0].delete();
        sb[1].delete();
        cur.delete();
        @(negedge clk);
        chk("rst_out_valid[20]", v20, 0);
        chk("rst_out_valid[17]", v17, 0);
        chk("rst_out_sum[20]", sum20, 0);
        chk("rst_out_sum[17]", sum17, 0);
        chk("rst_out_sat[20]", sat20, 0);
        chk("rst_out_sat[17]", sat17, 0);
        chk("rst_in_ready[20]", rdy20, 1);
        chk("rst_in_ready[17]", rdy17, 1);
        @(posedge clk); #1;
    endtask
    initial begin
        logic signed [7:0] a, b;
        logic signed [PW-1:0] p;
        int g;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_product = '0;
        out_ready  = 1'b1;
        do_reset();
        // back-to-back directed vector with latency and single-cycle in_ready drop
        send_list('{100, -50, 200, 0, 7, -7, 1, 1}, 0);
        @(negedge clk);
        chk("latency_out_valid", v20, 1);
        chk("directed_sum", sum20, 252);
        chk("directed_sat", sat20, 0);
        chk("hold_in_ready", rdy20, 0);
        @(negedge clk);
        chk("release_out_valid", v20, 0);
        chk("release_in_ready", rdy20, 1);
        @(posedge clk); #1;
        send_list('{16384, 16384, 16384, 16384, 16384, 16384, 16384, 16384}, 0);
        @(negedge clk);
        chk("pos_sum[20]", sum20, 131072);
        chk("pos_sat[20]", sat20, 0);
        chk("pos_sum[17]", sum17, 65535);
        chk("pos_sat[17]", sat17, 1);
        @(posedge clk); #1;
        send_list('{-16384, -16384, -16384, -16384, -16384, -16384, -16384, -16384}, 0);
        @(negedge clk);
        chk("neg_sum[17]", sum17, -65536);
        chk("neg_sat[17]", sat17, 1);
        @(posedge clk); #1;
        // bubbles on input, then back-pressure on output
        mode      = 2;
        out_ready = 1'b0;
        send_list('{100, -50, 200, 0, 7, -7, 1, 1}, 50);
        repeat (5) begin
            @(negedge clk);
            chk("stall_out_valid", v20, 1);
            chk("stall_in_ready", rdy20, 0);
            chk("stall_sum", sum20, 252);
        end
        @(posedge clk); #1;
        mode      = 0;
        out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        // abort mid-vector
        send_list('{5, 5, 5, 5}, 0);
        do_reset();
        send_list('{1, 1, 1, 1, 1, 1, 1, 1}, 0);
        @(negedge clk);
        chk("after_abort_sum", sum20, 8);
        chk("after_abort_valid", v20, 1);
        @(posedge clk); #1;
        // abort while a result is pending
        mode      = 2;
        out_ready = 1'b0;
        send_list('{3, 3, 3, 3, 3, 3, 3, 3}, 0);
        @(posedge clk); #1;
        do_reset();
        mode      = 0;
        out_ready = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        // random multiplier-like products, random bubbles and back-pressure
        mode = 1;
        repeat (12 * VL) begin
            a = 8'($urandom);
            b = 8'($urandom);
            p = a * b;
            if ($urandom_range(3) == 0) p = 16'($urandom);
            send(p, 30);
        end
        mode      = 0;
        out_ready = 1'b1;
        g = 0;
        while ((sb[0].size() != 0 || sb[1].size() != 0) && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        chk("drain[20]", sb[0].size(), 0);
        chk("drain[17]", sb[1].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter VEC_LEN, default 8, number of products summed per result (2..256).
REQ-002 SHALL have parameter PROD_W, default 16, signed product width (matches approx_log_multiplier result).
REQ-003 SHALL have parameter ACC_W, default 20, signed accumulator/result width (ACC_W > PROD_W).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-005 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-006 SHALL have port in_valid  input  1  in_product valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block accepts a product this cycle.
REQ-008 SHALL have port in_product  input  PROD_W  signed product from the multiplier.
REQ-009 SHALL have port out_valid  output  1  out_sum/out_sat hold a completed dot product.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port out_sum  output  ACC_W  signed saturated sum of VEC_LEN products.
REQ-012 SHALL have port out_sat  output  1  saturation occurred at any add within this vector.

Function
REQ-013 SHALL implement states IDLE, ACCUM, HOLD.
REQ-014 Input transfer SHALL occur only on cycles with in_valid && in_ready.
REQ-015 in_ready SHALL be 1 in IDLE and ACCUM, 0 in HOLD (combinational from state only).
REQ-016 IDLE: on transfer, acc <= sext(in_product), cnt <= 1, sat <= 0, go ACCUM (or HOLD if VEC_LEN reached).
REQ-017 ACCUM: on transfer, acc <= sat_add(acc, sext(in_product)), cnt <= cnt+1; no transfer leaves acc/cnt unchanged.
REQ-018 When the transfer that makes cnt == VEC_LEN occurs, SHALL go HOLD next cycle with out_valid=1 and out_sum = final acc (latency: 1 cycle after last accepted product).
REQ-019 sat_add SHALL clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; any clamp sets sticky sat for the vector.
REQ-020 HOLD: out_sum, out_sat SHALL remain stable while out_valid && !out_ready.
REQ-021 HOLD with out_ready=1: go IDLE next cycle, out_valid <= 0, cnt <= 0; no input accepted that cycle.
REQ-022 out_valid SHALL be 1 only in HOLD.
REQ-023 Gaps in in_valid (bubbles) SHALL not affect the sum or count.
REQ-024 Zero products SHALL count toward VEC_LEN like any other value.

Reset
REQ-025 rst=1 at posedge SHALL force state IDLE, acc=0, cnt=0, sat=0, out_valid=0, out_sum=0, out_sat=0, regardless of state.
REQ-026 Reset mid-vector (ACCUM) or mid-hold (HOLD) SHALL discard partial/pending result; no out_valid pulse follows.
REQ-027 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-028 Package acc_pkg SHALL hold the state enum (IDLE/ACCUM/HOLD) and default VEC_LEN/PROD_W/ACC_W constants.
REQ-029 Saturating adder SHALL be a sub-module sat_adder (ACC_W-bit signed, outputs sum and overflow flag).
REQ-030 Counter width SHALL be $clog2(VEC_LEN+1).

Verification
REQ-031 Products 100,-50,200,0,7,-7,1,1 back-to-back, out_ready=1 -> out_valid one cycle after 8th, out_sum=252, out_sat=0, in_ready low exactly one cycle.
REQ-032 Eight products of 16384 (-128*-128), ACC_W=20 -> out_sum=131072, out_sat=0; same with ACC_W=17 -> out_sum=65535, out_sat=1.
REQ-033 Eight products of -16384 with ACC_W=17 -> out_sum=-65536, out_sat=1.
REQ-034 Random in_valid bubbles (50%) on the REQ-031 sequence -> identical out_sum=252; out_ready held 0 for 5 cycles -> out_sum stable, in_ready=0 throughout.
REQ-035 rst asserted after 4 products accepted, then 8 products of 1 -> single result out_sum=8; no result from the aborted vector.
REQ-036 Chain with approx_log_multiplier: A,B sweep pairs feeding products; out_sum equals sum of observed multiplier results (not exact A*B).
